// File: rtl/dds_lut_sched.sv
// Two-channel DDS sharing one quarter-wave sine LUT; four-cycle schedule per sample tick.
// Optional square-wave output per channel when DDS_SQUARE_EN is defined (adds wave_sel).
module dds_lut_sched #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             phase_clr,
  input  logic             cfg_wr,
  input  logic [1:0]       cfg_sel,
  input  logic [ACC_W-1:0] cfg_data,
  output logic             cfg_ack,
  output logic [5:0]       lut_addr,
  input  logic [8:0]       lut_data,
`ifdef DDS_SQUARE_EN
  input  logic [1:0]       wave_sel,
`endif
  output logic [9:0]       out_a,
  output logic [9:0]       out_b,
  output logic             sample_valid,
  output logic             busy,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ACC, RD_A, RD_B} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc_a, acc_b, fw_a, fw_b;
  logic [7:0]       phoff_a, phoff_b;
  logic             pend_vld, pend_clr;
  logic [1:0]       pend_sel;
  logic [ACC_W-1:0] pend_data;
  logic [7:0]       p_b_q;
  logic             neg_a;
  logic [8:0]       mag_a;

  logic [7:0]       p_a, p_b;
  logic             apply_cfg;
  logic [1:0]       wr_sel;
  logic [ACC_W-1:0] wr_data;
  logic [9:0]       samp_a, samp_b;

  // Quadrant fold: odd quadrants walk the table backwards (63 - idx == ~idx).
  function automatic logic [5:0] fold(input logic [7:0] p);
    return p[6] ? ~p[5:0] : p[5:0];
  endfunction

  function automatic logic [9:0] unfold(input logic neg, input logic [8:0] mag);
    return neg ? {1'b0, ~mag} : {1'b1, mag};
  endfunction

  assign p_a = acc_a[ACC_W-1 -: 8] + phoff_a;
  assign p_b = acc_b[ACC_W-1 -: 8] + phoff_b;

  // A held write takes priority; otherwise a write arriving in IDLE is applied directly.
  assign apply_cfg = (state == IDLE) && (pend_vld || cfg_wr);
  assign wr_sel    = pend_vld ? pend_sel  : cfg_sel;
  assign wr_data   = pend_vld ? pend_data : cfg_data;
  assign cfg_ack   = apply_cfg;
  assign busy      = (state != IDLE);

`ifdef DDS_SQUARE_EN
  assign samp_a = wave_sel[0] ? (neg_a    ? 10'h000 : 10'h3FF) : unfold(neg_a, mag_a);
  assign samp_b = wave_sel[1] ? (p_b_q[7] ? 10'h000 : 10'h3FF) : unfold(p_b_q[7], lut_data);
`else
  assign samp_a = unfold(neg_a, mag_a);
  assign samp_b = unfold(p_b_q[7], lut_data);
`endif

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      acc_a        <= '0;
      acc_b        <= '0;
      fw_a         <= '0;
      fw_b         <= '0;
      phoff_a      <= '0;
      phoff_b      <= '0;
      pend_vld     <= 1'b0;
      pend_clr     <= 1'b0;
      pend_sel     <= '0;
      pend_data    <= '0;
      p_b_q        <= '0;
      neg_a        <= 1'b0;
      mag_a        <= '0;
      lut_addr     <= '0;
      out_a        <= 10'h200;
      out_b        <= 10'h200;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      overrun      <= 1'b0;

      if (state != IDLE) begin
        if (cfg_wr && !pend_vld) begin
          pend_vld  <= 1'b1;
          pend_sel  <= cfg_sel;
          pend_data <= cfg_data;
        end
        if (phase_clr) pend_clr <= 1'b1;
        if (tick && en) overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (apply_cfg) begin
            case (wr_sel)
              2'd0: fw_a    <= wr_data;
              2'd1: phoff_a <= wr_data[7:0];
              2'd2: fw_b    <= wr_data;
              2'd3: phoff_b <= wr_data[7:0];
              default: ;
            endcase
            pend_vld <= 1'b0;
          end
          if (phase_clr || pend_clr) begin
            acc_a    <= '0;
            acc_b    <= '0;
            pend_clr <= 1'b0;
          end
          if (tick && en) state <= ACC;
        end
        ACC: begin
          acc_a    <= acc_a + fw_a;
          acc_b    <= acc_b + fw_b;
          lut_addr <= fold(p_a);
          neg_a    <= p_a[7];
          p_b_q    <= p_b;
          state    <= RD_A;
        end
        RD_A: begin
          mag_a    <= lut_data;
          lut_addr <= fold(p_b_q);
          state    <= RD_B;
        end
        RD_B: begin
          out_a        <= samp_a;
          out_b        <= samp_b;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_lut_sched.sv
// Directed bench for dds_lut_sched: sine LUT model, schedule, config handshake, overrun, phase clear.
module tb_dds_lut_sched;
  localparam int ACC_W = 32;
  localparam logic [ACC_W-1:0] STEP1 = 32'h0100_0000;

  logic             clk = 1'b0;
  logic             rst, en, tick, phase_clr, cfg_wr;
  logic [1:0]       cfg_sel;
  logic [ACC_W-1:0] cfg_data;
  logic             cfg_ack, sample_valid, busy, overrun;
  logic [5:0]       lut_addr;
  logic [8:0]       lut_data;
  logic [9:0]       out_a, out_b;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] rom [64];

  dds_lut_sched #(.ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .en(en), .tick(tick), .phase_clr(phase_clr),
    .cfg_wr(cfg_wr), .cfg_sel(cfg_sel), .cfg_data(cfg_data), .cfg_ack(cfg_ack),
    .lut_addr(lut_addr), .lut_data(lut_data), .out_a(out_a), .out_b(out_b),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Quarter-wave table: floor(511*sin(2*pi*i/256)), last entry pinned to full scale.
  initial begin
    for (int i = 0; i < 64; i++)
      rom[i] = 9'($rtoi(511.0 * $sin(6.283185307179586 * i / 256.0)));
    rom[63] = 9'd511;
  end
  assign lut_data = rom[lut_addr];

  // Issue one tick in the current cycle and wait for the sample; lat = -1 on timeout.
  task automatic do_sample(input logic clr, output logic [9:0] a, output logic [9:0] b,
                           output int lat);
    lat = -1; a = '0; b = '0;
    tick = 1'b1; phase_clr = clr;
    @(posedge clk); #1;
    tick = 1'b0; phase_clr = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sample_valid) begin
        lat = k; a = out_a; b = out_b;
        break;
      end
    end
  endtask

  task automatic wr_cfg(input logic [1:0] sel, input logic [ACC_W-1:0] data, output logic ack);
    cfg_wr = 1'b1; cfg_sel = sel; cfg_data = data;
    #1 ack = cfg_ack;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    phase_clr = 1'b1;
    @(posedge clk); #1;
    phase_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [4:1] busy_seen, sv_seen;
    logic [9:0] a, b;
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({out_a, out_b} !== {10'h200, 10'h200}) begin
      miscompares++; $display("FAIL reset_out got %h/%h want 200/200", out_a, out_b);
    end
    vectors++;
    if ({lut_addr, sample_valid, cfg_ack, busy, overrun} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_ctl got addr=%0d sv=%b ack=%b busy=%b ov=%b want all 0",
               lut_addr, sample_valid, cfg_ack, busy, overrun);
    end
    rst = 1'b0;
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      busy_seen[k] = busy; sv_seen[k] = sample_valid;
      if (k == 4) begin a = out_a; b = out_b; end
    end
    vectors++;
    if (busy_seen !== 4'b0111) begin
      miscompares++; $display("FAIL reset_busy got %b want 0111 (cycles 4..1)", busy_seen);
    end
    vectors++;
    if (sv_seen !== 4'b1000) begin
      miscompares++; $display("FAIL reset_latency got %b want 1000 (cycles 4..1)", sv_seen);
    end
    vectors++;
    if ({a, b} !== {10'h200, 10'h200}) begin
      miscompares++; $display("FAIL reset_sample got %h/%h want 200/200", a, b);
    end
  endtask

  task automatic test_sweep();
    logic [9:0] exp_a [4] = '{10'h200, 10'h20C, 10'h219, 10'h225};
    logic [9:0] a, b;
    logic ack;
    int lat;
    wr_cfg(2'd0, STEP1, ack);
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL sweep_ack got %b want 1", ack); end
    for (int i = 0; i < 4; i++) begin
      do_sample(1'b0, a, b, lat);
      vectors++;
      if (lat !== 4 || a !== exp_a[i] || b !== 10'h200) begin
        miscompares++;
        $display("FAIL sweep[%0d] got lat=%0d a=%h b=%h want lat=4 a=%h b=200",
                 i, lat, a, b, exp_a[i]);
      end
    end
  endtask

  task automatic test_quadrants();
    logic [7:0] ph    [5] = '{8'd64, 8'd128, 8'd192, 8'd127, 8'd255};
    logic [9:0] exp_a [5] = '{10'h3FF, 10'h1FF, 10'h000, 10'h200, 10'h1FF};
    logic [9:0] a, b;
    logic ack;
    int lat;
    pulse_clr();
    wr_cfg(2'd0, '0, ack);
    for (int i = 0; i < 5; i++) begin
      wr_cfg(2'd1, ACC_W'(ph[i]), ack);
      do_sample(1'b0, a, b, lat);
      vectors++;
      if (lat !== 4 || a !== exp_a[i] || b !== 10'h200) begin
        miscompares++;
        $display("FAIL quad p=%0d got lat=%0d a=%h b=%h want lat=4 a=%h b=200",
                 ph[i], lat, a, b, exp_a[i]);
      end
    end
  endtask

  task automatic test_channel_b();
    logic [9:0] exp_a [4] = '{10'h200, 10'h20C, 10'h219, 10'h225};
    logic [9:0] a, b, exp_b;
    logic ack;
    int lat;
    wr_cfg(2'd1, '0, ack);
    wr_cfg(2'd0, STEP1, ack);
    wr_cfg(2'd3, ACC_W'(64), ack);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) wr_cfg(2'd3, ACC_W'(192), ack);
      exp_b = (i < 2) ? 10'h3FF : 10'h000;
      do_sample(1'b0, a, b, lat);
      vectors++;
      if (lat !== 4 || a !== exp_a[i] || b !== exp_b) begin
        miscompares++;
        $display("FAIL chan_b[%0d] got lat=%0d a=%h b=%h want lat=4 a=%h b=%h",
                 i, lat, a, b, exp_a[i], exp_b);
      end
    end
  endtask

  task automatic test_cfg_pending();
    logic [3:0] acks;
    logic [9:0] a, b;
    int lat;
    pulse_clr();
    tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    cfg_wr = 1'b1; cfg_sel = 2'd0; cfg_data = 2 * STEP1;
    @(negedge clk); acks[0] = cfg_ack;
    @(posedge clk); #1;
    cfg_data = 5 * STEP1;
    @(negedge clk); acks[1] = cfg_ack;
    @(posedge clk); #1;
    cfg_wr = 1'b0;
    @(negedge clk); acks[2] = cfg_ack; a = out_a;
    vectors++;
    if (sample_valid !== 1'b1 || a !== 10'h200) begin
      miscompares++; $display("FAIL pend_sample got sv=%b a=%h want sv=1 a=200", sample_valid, a);
    end
    @(posedge clk); #1;
    @(negedge clk); acks[3] = cfg_ack;
    vectors++;
    if (acks !== 4'b0100) begin
      miscompares++; $display("FAIL pend_ack got %b want 0100 (cycles 5..2)", acks);
    end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h20C) begin miscompares++; $display("FAIL pend_val0 got a=%h want 20C", a); end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h225) begin miscompares++; $display("FAIL pend_val1 got a=%h want 225", a); end
  endtask

  task automatic test_overrun();
    int ov, sv, bz;
    ov = 0; sv = 0;
    tick = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (k == 4) tick = 1'b0;
      @(negedge clk);
      ov += int'(overrun); sv += int'(sample_valid);
    end
    vectors++;
    if (ov !== 3 || sv !== 1) begin
      miscompares++; $display("FAIL overrun got ov=%0d sv=%0d want ov=3 sv=1", ov, sv);
    end
    ov = 0; sv = 0; bz = 0;
    en = 1'b0; tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      tick = 1'b0;
      @(negedge clk);
      ov += int'(overrun); sv += int'(sample_valid); bz += int'(busy);
    end
    vectors++;
    if (ov !== 0 || sv !== 0 || bz !== 0) begin
      miscompares++; $display("FAIL en_off got ov=%0d sv=%0d busy=%0d want 0/0/0", ov, sv, bz);
    end
    en = 1'b1; tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0; en = 1'b0;
    sv = -1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (sample_valid) begin sv = k; break; end
    end
    en = 1'b1;
    vectors++;
    if (sv !== 4) begin miscompares++; $display("FAIL en_drop got lat=%0d want 4", sv); end
  endtask

  task automatic test_phase_clr_tick();
    logic [9:0] a, b;
    logic ack;
    int lat;
    wr_cfg(2'd0, STEP1, ack);
    do_sample(1'b1, a, b, lat);
    vectors++;
    if (a !== 10'h200) begin miscompares++; $display("FAIL clr_tick got a=%h want 200", a); end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h20C) begin miscompares++; $display("FAIL clr_next got a=%h want 20C", a); end
    tick = 1'b1;
    @(posedge clk); #1; tick = 1'b0;
    @(posedge clk); #1; phase_clr = 1'b1;
    @(posedge clk); #1; phase_clr = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (sample_valid !== 1'b1 || out_a !== 10'h219) begin
      miscompares++;
      $display("FAIL clr_busy got sv=%b a=%h want sv=1 a=219", sample_valid, out_a);
    end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h200) begin miscompares++; $display("FAIL clr_pending got a=%h want 200", a); end
    phase_clr = 1'b1;
    wr_cfg(2'd0, 3 * STEP1, ack);
    phase_clr = 1'b0;
    vectors++;
    if (ack !== 1'b1) begin miscompares++; $display("FAIL clr_cfg_ack got %b want 1", ack); end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h200) begin miscompares++; $display("FAIL clr_cfg0 got a=%h want 200", a); end
    do_sample(1'b0, a, b, lat);
    vectors++;
    if (a !== 10'h225) begin miscompares++; $display("FAIL clr_cfg1 got a=%h want 225", a); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; tick = 1'b0; phase_clr = 1'b0;
    cfg_wr = 1'b0; cfg_sel = '0; cfg_data = '0;
    test_reset();
    test_sweep();
    test_quadrants();
    test_channel_b();
    test_cfg_pending();
    test_overrun();
    test_phase_clr_tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
